// File: rtl/reservation_station_pkg.sv
// Shared widths, opcodes and entry layout for the integer reservation station.
// Oldest-first issue is built when RS_AGE_SELECT_EN is defined.
package reservation_station_pkg;

  localparam int RS_SIZE = 16;
  localparam int ROB_W   = 4;
  localparam int DATA_W  = 32;
  localparam int OP_W    = 6;

  localparam logic TRUE  = 1'b1;
  localparam logic FALSE = 1'b0;

  typedef enum logic [OP_W-1:0] {
    OP_ADD   = 6'd0,
    OP_SUB   = 6'd1,
    OP_AND   = 6'd2,
    OP_OR    = 6'd3,
    OP_XOR   = 6'd4,
    OP_SLL   = 6'd5,
    OP_SRL   = 6'd6,
    OP_SRA   = 6'd7,
    OP_SLT   = 6'd8,
    OP_SLTU  = 6'd9,
    OP_BEQ   = 6'd10,
    OP_BNE   = 6'd11,
    OP_BLT   = 6'd12,
    OP_BGE   = 6'd13,
    OP_BLTU  = 6'd14,
    OP_BGEU  = 6'd15,
    OP_JAL   = 6'd16,
    OP_JALR  = 6'd17,
    OP_LUI   = 6'd18,
    OP_AUIPC = 6'd19
  } alu_op_e;

  typedef struct packed {
    logic              rdy;
    logic [ROB_W-1:0]  tag;
    logic [DATA_W-1:0] val;
  } rs_opnd_t;

  typedef struct packed {
    logic             busy;
    logic [OP_W-1:0]  op;
    logic [31:0]      pc;
    logic [31:0]      imm;
    logic [ROB_W-1:0] rd;
    rs_opnd_t         s1;
    rs_opnd_t         s2;
  } rs_entry_t;

  typedef struct packed {
    logic [OP_W-1:0]   op;
    logic [31:0]       pc;
    logic [31:0]       imm;
    logic [ROB_W-1:0]  rd;
    logic [DATA_W-1:0] v1;
    logic [DATA_W-1:0] v2;
  } rs_issue_t;

  // ALU broadcast takes precedence when both buses carry the tag
  function automatic rs_opnd_t cdb_snoop(
    input rs_opnd_t          o,
    input logic              av,
    input logic [ROB_W-1:0]  at,
    input logic [DATA_W-1:0] ad,
    input logic              lv,
    input logic [ROB_W-1:0]  lt,
    input logic [DATA_W-1:0] ld
  );
    rs_opnd_t r;
    r = o;
    if (!o.rdy) begin
      if (av && at == o.tag) begin
        r.rdy = TRUE;
        r.val = ad;
      end else if (lv && lt == o.tag) begin
        r.rdy = TRUE;
        r.val = ld;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/reservation_station_select.sv
// One-hot picker: lowest index, or oldest requester when RS_AGE_SELECT_EN.
// age_i[i][j] set means entry j is older than entry i.
module rs_select
  import reservation_station_pkg::*;
#(
  parameter int N = RS_SIZE
`ifdef RS_AGE_SELECT_EN
  ,
  parameter bit OLDEST = 1'b0
`endif
) (
  input  logic [N-1:0]        req_i,
`ifdef RS_AGE_SELECT_EN
  input  logic [N-1:0][N-1:0] age_i,
`endif
  output logic [N-1:0]        gnt_o,
  output logic                valid_o
);

  assign valid_o = |req_i;

`ifdef RS_AGE_SELECT_EN
  if (OLDEST) begin : g_old
    always_comb begin
      gnt_o = '0;
      for (int i = 0; i < N; i++) begin
        gnt_o[i] = req_i[i] && !(|(age_i[i] & req_i));
      end
    end
  end else begin : g_low
    assign gnt_o = req_i & (-req_i);
  end
`else
  assign gnt_o = req_i & (-req_i);
`endif

endmodule

// File: rtl/reservation_station.sv
// Integer reservation station: dispatch, CDB wakeup, single issue to ALU.
// Define RS_AGE_SELECT_EN for oldest-ready issue instead of lowest index.
module reservation_station
  import reservation_station_pkg::*;
#(
  parameter int N = RS_SIZE
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rdy,
  input  logic              flush,
  input  logic              disp_valid,
  input  logic [OP_W-1:0]   disp_op,
  input  logic [31:0]       disp_pc,
  input  logic [31:0]       disp_imm,
  input  logic [ROB_W-1:0]  disp_rd_rename,
  input  logic              disp_rs1_ready,
  input  logic              disp_rs2_ready,
  input  logic [DATA_W-1:0] disp_rs1_value,
  input  logic [DATA_W-1:0] disp_rs2_value,
  input  logic [ROB_W-1:0]  disp_rs1_tag,
  input  logic [ROB_W-1:0]  disp_rs2_tag,
  output logic              rs_full,
  input  logic              alu_cdb_valid,
  input  logic [ROB_W-1:0]  alu_cdb_tag,
  input  logic [DATA_W-1:0] alu_cdb_value,
  input  logic              lsb_cdb_valid,
  input  logic [ROB_W-1:0]  lsb_cdb_tag,
  input  logic [DATA_W-1:0] lsb_cdb_value,
  output logic              alu_enable,
  output logic [ROB_W-1:0]  alu_rd_rename,
  output logic [31:0]       alu_pc,
  output logic [31:0]       alu_imm,
  output logic [DATA_W-1:0] alu_rs1_value,
  output logic [DATA_W-1:0] alu_rs2_value,
  output logic [OP_W-1:0]   alu_op
);

  rs_entry_t ent_q [N];
  rs_entry_t ent_d [N];
  rs_issue_t iss_q, iss_d;
  logic      en_q, en_d;

  logic [N-1:0] busy, cand;
  logic [N-1:0] free_gnt, iss_gnt;
  logic         free_vld, iss_vld;
  rs_opnd_t     d1_raw, d2_raw, d1, d2;

`ifdef RS_AGE_SELECT_EN
  logic [N-1:0][N-1:0] age_q, age_d;
`endif

  always_comb begin
    for (int i = 0; i < N; i++) begin
      busy[i] = ent_q[i].busy;
      cand[i] = ent_q[i].busy && ent_q[i].s1.rdy && ent_q[i].s2.rdy;
    end
  end

  rs_select #(
    .N(N)
  ) u_free (
    .req_i  (~busy),
`ifdef RS_AGE_SELECT_EN
    .age_i  ('0),
`endif
    .gnt_o  (free_gnt),
    .valid_o(free_vld)
  );

  rs_select #(
    .N(N)
`ifdef RS_AGE_SELECT_EN
    ,
    .OLDEST(1'b1)
`endif
  ) u_issue (
    .req_i  (cand),
`ifdef RS_AGE_SELECT_EN
    .age_i  (age_q),
`endif
    .gnt_o  (iss_gnt),
    .valid_o(iss_vld)
  );

  assign rs_full = ~free_vld;

  assign d1_raw = '{rdy: disp_rs1_ready,
                    tag: disp_rs1_tag,
                    val: disp_rs1_value};
  assign d2_raw = '{rdy: disp_rs2_ready,
                    tag: disp_rs2_tag,
                    val: disp_rs2_value};

  assign d1 = cdb_snoop(d1_raw,
                        alu_cdb_valid, alu_cdb_tag, alu_cdb_value,
                        lsb_cdb_valid, lsb_cdb_tag, lsb_cdb_value);
  assign d2 = cdb_snoop(d2_raw,
                        alu_cdb_valid, alu_cdb_tag, alu_cdb_value,
                        lsb_cdb_valid, lsb_cdb_tag, lsb_cdb_value);

  always_comb begin
    ent_d = ent_q;
    iss_d = iss_q;
    en_d  = en_q;
`ifdef RS_AGE_SELECT_EN
    age_d = age_q;
`endif
    if (rdy) begin
      en_d = FALSE;
      if (flush) begin
        for (int i = 0; i < N; i++) begin
          ent_d[i].busy = FALSE;
        end
`ifdef RS_AGE_SELECT_EN
        age_d = '0;
`endif
      end else begin
        for (int i = 0; i < N; i++) begin
          if (ent_q[i].busy) begin
            ent_d[i].s1 = cdb_snoop(ent_q[i].s1,
              alu_cdb_valid, alu_cdb_tag, alu_cdb_value,
              lsb_cdb_valid, lsb_cdb_tag, lsb_cdb_value);
            ent_d[i].s2 = cdb_snoop(ent_q[i].s2,
              alu_cdb_valid, alu_cdb_tag, alu_cdb_value,
              lsb_cdb_valid, lsb_cdb_tag, lsb_cdb_value);
          end
        end
        en_d = iss_vld;
        for (int i = 0; i < N; i++) begin
          if (iss_gnt[i]) begin
            iss_d.op      = ent_q[i].op;
            iss_d.pc      = ent_q[i].pc;
            iss_d.imm     = ent_q[i].imm;
            iss_d.rd      = ent_q[i].rd;
            iss_d.v1      = ent_q[i].s1.val;
            iss_d.v2      = ent_q[i].s2.val;
            ent_d[i].busy = FALSE;
`ifdef RS_AGE_SELECT_EN
            age_d[i] = '0;
            for (int j = 0; j < N; j++) begin
              age_d[j][i] = 1'b0;
            end
`endif
          end
        end
        // free slot comes from registered occupancy, never the one issuing now
        if (disp_valid && free_vld) begin
          for (int i = 0; i < N; i++) begin
            if (free_gnt[i]) begin
              ent_d[i].busy = TRUE;
              ent_d[i].op   = disp_op;
              ent_d[i].pc   = disp_pc;
              ent_d[i].imm  = disp_imm;
              ent_d[i].rd   = disp_rd_rename;
              ent_d[i].s1   = d1;
              ent_d[i].s2   = d2;
`ifdef RS_AGE_SELECT_EN
              age_d[i] = busy & ~iss_gnt;
`endif
            end
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < N; i++) begin
        ent_q[i] <= '0;
      end
      iss_q <= '0;
      en_q  <= FALSE;
`ifdef RS_AGE_SELECT_EN
      age_q <= '0;
`endif
    end else begin
      ent_q <= ent_d;
      iss_q <= iss_d;
      en_q  <= en_d;
`ifdef RS_AGE_SELECT_EN
      age_q <= age_d;
`endif
    end
  end

  assign alu_enable    = en_q;
  assign alu_op        = iss_q.op;
  assign alu_pc        = iss_q.pc;
  assign alu_imm       = iss_q.imm;
  assign alu_rd_rename = iss_q.rd;
  assign alu_rs1_value = iss_q.v1;
  assign alu_rs2_value = iss_q.v2;

`ifndef SYNTHESIS
  always_ff @(posedge clk) begin
    if (rst && rdy && disp_valid && !flush) begin
      assert (!rs_full)
      else $error("reservation_station: dispatch while full");
    end
  end
`endif

endmodule

// File: tb/tb_reservation_station.sv
// Directed and randomized checks of reservation_station against a
// queue-level reference model of dispatch, wakeup and issue.
module tb_reservation_station;
  import reservation_station_pkg::*;

  logic              clk = 1'b0;
  logic              rst, rdy, flush, disp_valid;
  logic [OP_W-1:0]   disp_op;
  logic [31:0]       disp_pc, disp_imm;
  logic [ROB_W-1:0]  disp_rd_rename, disp_rs1_tag, disp_rs2_tag;
  logic              disp_rs1_ready, disp_rs2_ready;
  logic [DATA_W-1:0] disp_rs1_value, disp_rs2_value;
  logic              rs_full;
  logic              alu_cdb_valid, lsb_cdb_valid;
  logic [ROB_W-1:0]  alu_cdb_tag, lsb_cdb_tag;
  logic [DATA_W-1:0] alu_cdb_value, lsb_cdb_value;
  logic              alu_enable;
  logic [ROB_W-1:0]  alu_rd_rename;
  logic [31:0]       alu_pc, alu_imm;
  logic [DATA_W-1:0] alu_rs1_value, alu_rs2_value;
  logic [OP_W-1:0]   alu_op;

  always #5 clk = ~clk;

  reservation_station dut (
    .clk           (clk),
    .rst           (rst),
    .rdy           (rdy),
    .flush         (flush),
    .disp_valid    (disp_valid),
    .disp_op       (disp_op),
    .disp_pc       (disp_pc),
    .disp_imm      (disp_imm),
    .disp_rd_rename(disp_rd_rename),
    .disp_rs1_ready(disp_rs1_ready),
    .disp_rs2_ready(disp_rs2_ready),
    .disp_rs1_value(disp_rs1_value),
    .disp_rs2_value(disp_rs2_value),
    .disp_rs1_tag  (disp_rs1_tag),
    .disp_rs2_tag  (disp_rs2_tag),
    .rs_full       (rs_full),
    .alu_cdb_valid (alu_cdb_valid),
    .alu_cdb_tag   (alu_cdb_tag),
    .alu_cdb_value (alu_cdb_value),
    .lsb_cdb_valid (lsb_cdb_valid),
    .lsb_cdb_tag   (lsb_cdb_tag),
    .lsb_cdb_value (lsb_cdb_value),
    .alu_enable    (alu_enable),
    .alu_rd_rename (alu_rd_rename),
    .alu_pc        (alu_pc),
    .alu_imm       (alu_imm),
    .alu_rs1_value (alu_rs1_value),
    .alu_rs2_value (alu_rs2_value),
    .alu_op        (alu_op)
  );

  int total = 0;
  int bad   = 0;

  // reference model: one record per slot plus a dispatch sequence number
  bit                mb  [RS_SIZE];
  logic [OP_W-1:0]   mop [RS_SIZE];
  logic [31:0]       mpc [RS_SIZE];
  logic [31:0]       mimm[RS_SIZE];
  logic [ROB_W-1:0]  mrd [RS_SIZE];
  bit                mr1 [RS_SIZE];
  bit                mr2 [RS_SIZE];
  logic [ROB_W-1:0]  mt1 [RS_SIZE];
  logic [ROB_W-1:0]  mt2 [RS_SIZE];
  logic [DATA_W-1:0] mv1 [RS_SIZE];
  logic [DATA_W-1:0] mv2 [RS_SIZE];
  int                mseq[RS_SIZE];
  int                seqn = 0;
  bit                m_en;
  logic [OP_W-1:0]   m_op;
  logic [31:0]       m_pc, m_imm;
  logic [ROB_W-1:0]  m_rd;
  logic [DATA_W-1:0] m_v1, m_v2;

  task automatic model_reset();
    for (int i = 0; i < RS_SIZE; i++) mb[i] = 1'b0;
    m_en = 0; m_op = '0; m_pc = '0; m_imm = '0;
    m_rd = '0; m_v1 = '0; m_v2 = '0;
  endtask

  function automatic bit m_full();
    for (int i = 0; i < RS_SIZE; i++) if (!mb[i]) return 1'b0;
    return 1'b1;
  endfunction

  task automatic snoop(input bit r, input logic [ROB_W-1:0] t,
                       input logic [DATA_W-1:0] v,
                       output bit ro, output logic [DATA_W-1:0] vo);
    ro = r; vo = v;
    if (!r) begin
      if (alu_cdb_valid && alu_cdb_tag == t) begin
        ro = 1'b1; vo = alu_cdb_value;
      end else if (lsb_cdb_valid && lsb_cdb_tag == t) begin
        ro = 1'b1; vo = lsb_cdb_value;
      end
    end
  endtask

  task automatic model_step();
    int win, fr;
    if (!rst) begin model_reset(); return; end
    if (!rdy) return;
    if (flush) begin
      for (int i = 0; i < RS_SIZE; i++) mb[i] = 1'b0;
      m_en = 0;
      return;
    end
    win = -1; fr = -1;
    for (int i = 0; i < RS_SIZE; i++) begin
      if (mb[i] && mr1[i] && mr2[i]) begin
`ifdef RS_AGE_SELECT_EN
        if (win < 0 || mseq[i] < mseq[win]) win = i;
`else
        if (win < 0) win = i;
`endif
      end
      if (!mb[i] && fr < 0) fr = i;
    end
    for (int i = 0; i < RS_SIZE; i++) begin
      if (mb[i]) begin
        snoop(mr1[i], mt1[i], mv1[i], mr1[i], mv1[i]);
        snoop(mr2[i], mt2[i], mv2[i], mr2[i], mv2[i]);
      end
    end
    m_en = (win >= 0);
    if (win >= 0) begin
      m_op = mop[win]; m_pc = mpc[win]; m_imm = mimm[win];
      m_rd = mrd[win]; m_v1 = mv1[win]; m_v2 = mv2[win];
      mb[win] = 1'b0;
    end
    if (disp_valid && fr >= 0) begin
      mb[fr] = 1'b1; mop[fr] = disp_op; mpc[fr] = disp_pc;
      mimm[fr] = disp_imm; mrd[fr] = disp_rd_rename;
      mt1[fr] = disp_rs1_tag; mt2[fr] = disp_rs2_tag;
      snoop(disp_rs1_ready, disp_rs1_tag, disp_rs1_value, mr1[fr], mv1[fr]);
      snoop(disp_rs2_ready, disp_rs2_tag, disp_rs2_value, mr2[fr], mv2[fr]);
      mseq[fr] = seqn;
      seqn++;
    end
  endtask

  task automatic idle();
    rdy = 1'b1; flush = 1'b0; disp_valid = 1'b0;
    disp_op = '0; disp_pc = '0; disp_imm = '0; disp_rd_rename = '0;
    disp_rs1_ready = 1'b0; disp_rs2_ready = 1'b0;
    disp_rs1_value = '0; disp_rs2_value = '0;
    disp_rs1_tag = '0; disp_rs2_tag = '0;
    alu_cdb_valid = 1'b0; alu_cdb_tag = '0; alu_cdb_value = '0;
    lsb_cdb_valid = 1'b0; lsb_cdb_tag = '0; lsb_cdb_value = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic drive_disp(
    input logic [OP_W-1:0] op, input logic [ROB_W-1:0] rd,
    input bit r1, input logic [DATA_W-1:0] v1, input logic [ROB_W-1:0] t1,
    input bit r2, input logic [DATA_W-1:0] v2, input logic [ROB_W-1:0] t2);
    disp_valid = 1'b1; disp_op = op; disp_rd_rename = rd;
    disp_pc = 32'h1000 | {26'd0, rd, 2'b00};
    disp_imm = 32'hFFFF_FF00 | {28'd0, rd};
    disp_rs1_ready = r1; disp_rs1_value = v1; disp_rs1_tag = t1;
    disp_rs2_ready = r2; disp_rs2_value = v2; disp_rs2_tag = t2;
  endtask

  task automatic test_reset();
    idle();
    rst = 1'b0;
    repeat (2) @(negedge clk);
    model_reset();
    total++;
    if ({alu_enable, rs_full, alu_rd_rename, alu_pc, alu_rs1_value} !== '0) begin
      bad++;
      $display("FAIL reset: en=%0b full=%0b rd=%0h pc=%0h v1=%0h want all 0",
               alu_enable, rs_full, alu_rd_rename, alu_pc, alu_rs1_value);
    end
    rst = 1'b1;
  endtask

  task automatic test_basic_issue();
    drive_disp(OP_ADD, 4'd2, 1, 32'd5, 4'd0, 1, 32'd7, 4'd0);
    tick(); idle();
    total++;
    if (alu_enable !== 1'b0) begin
      bad++; $display("FAIL basic_early: en=%0b want 0", alu_enable);
    end
    tick();
    total++;
    if ({alu_enable, alu_rs1_value, alu_rs2_value, alu_rd_rename, alu_op}
        !== {1'b1, 32'd5, 32'd7, 4'd2, OP_ADD}) begin
      bad++;
      $display("FAIL basic_issue: en=%0b v1=%0h v2=%0h rd=%0h op=%0h want 1 5 7 2 0",
               alu_enable, alu_rs1_value, alu_rs2_value, alu_rd_rename, alu_op);
    end
    tick();
    total++;
    if ({alu_enable, alu_rs1_value} !== {1'b0, 32'd5}) begin
      bad++;
      $display("FAIL basic_pulse: en=%0b v1=%0h want 0 5", alu_enable, alu_rs1_value);
    end
  endtask

  task automatic test_cdb_wakeup();
    drive_disp(OP_SUB, 4'd6, 0, 32'd0, 4'd3, 1, 32'd1, 4'd0);
    tick(); idle(); tick();
    alu_cdb_valid = 1'b1; alu_cdb_tag = 4'd3; alu_cdb_value = 32'h1234;
    tick(); idle();
    total++;
    if (alu_enable !== 1'b0) begin
      bad++; $display("FAIL wake_same_cycle: en=%0b want 0", alu_enable);
    end
    tick();
    total++;
    if ({alu_enable, alu_rs1_value, alu_rd_rename} !== {1'b1, 32'h1234, 4'd6}) begin
      bad++;
      $display("FAIL cdb_wakeup: en=%0b v1=%0h rd=%0h want 1 1234 6",
               alu_enable, alu_rs1_value, alu_rd_rename);
    end
  endtask

  task automatic test_dispatch_snoop();
    drive_disp(OP_XOR, 4'd8, 1, 32'd3, 4'd0, 0, 32'd0, 4'd9);
    lsb_cdb_valid = 1'b1; lsb_cdb_tag = 4'd9; lsb_cdb_value = 32'd42;
    tick(); idle(); tick();
    total++;
    if ({alu_enable, alu_rs2_value, alu_rd_rename} !== {1'b1, 32'd42, 4'd8}) begin
      bad++;
      $display("FAIL disp_snoop: en=%0b v2=%0h rd=%0h want 1 2a 8",
               alu_enable, alu_rs2_value, alu_rd_rename);
    end
    tick();
  endtask

  task automatic test_full();
    for (int i = 0; i < RS_SIZE; i++) begin
      total++;
      if (rs_full !== 1'b0) begin
        bad++; $display("FAIL fill_not_full: slot=%0d full=%0b want 0", i, rs_full);
      end
      drive_disp(OP_OR, 4'(i), 0, 32'd0, 4'd5, 1, 32'(i), 4'd0);
      tick();
    end
    idle();
    total++;
    if ({rs_full, alu_enable} !== 2'b10) begin
      bad++; $display("FAIL full_flag: full=%0b en=%0b want 1 0", rs_full, alu_enable);
    end
    alu_cdb_valid = 1'b1; alu_cdb_tag = 4'd5; alu_cdb_value = 32'hBEEF;
    tick(); idle();
    for (int k = 0; k < RS_SIZE; k++) begin
      tick();
      total++;
      if ({alu_enable, alu_rd_rename, alu_rs1_value, alu_rs2_value}
          !== {1'b1, 4'(k), 32'hBEEF, 32'(k)}) begin
        bad++;
        $display("FAIL drain: k=%0d en=%0b rd=%0h v1=%0h v2=%0h want 1 %0h beef %0h",
                 k, alu_enable, alu_rd_rename, alu_rs1_value, alu_rs2_value, k, k);
      end
      if (k == 0) begin
        total++;
        if (rs_full !== 1'b0) begin
          bad++; $display("FAIL drain_full: full=%0b want 0", rs_full);
        end
      end
    end
    tick();
    total++;
    if (alu_enable !== 1'b0) begin
      bad++; $display("FAIL drain_end: en=%0b want 0", alu_enable);
    end
  endtask

  task automatic test_flush();
    for (int i = 1; i <= 3; i++) begin
      drive_disp(OP_AND, 4'(i), 0, 32'd0, 4'd7, 1, 32'd1, 4'd0);
      tick();
    end
    drive_disp(OP_ADD, 4'd4, 1, 32'd1, 4'd0, 1, 32'd2, 4'd0);
    tick();
    drive_disp(OP_ADD, 4'd5, 1, 32'd3, 4'd0, 1, 32'd4, 4'd0);
    flush = 1'b1;
    tick(); idle();
    total++;
    if ({alu_enable, rs_full} !== 2'b00) begin
      bad++; $display("FAIL flush: en=%0b full=%0b want 0 0", alu_enable, rs_full);
    end
    alu_cdb_valid = 1'b1; alu_cdb_tag = 4'd7; alu_cdb_value = 32'd9;
    tick(); idle();
    for (int k = 0; k < 3; k++) begin
      tick();
      total++;
      if (alu_enable !== 1'b0) begin
        bad++; $display("FAIL flush_empty: cyc=%0d en=%0b want 0", k, alu_enable);
      end
    end
    drive_disp(OP_ADD, 4'd3, 1, 32'hAA, 4'd0, 1, 32'hBB, 4'd0);
    tick(); idle(); tick();
    total++;
    if ({alu_enable, alu_rs1_value} !== {1'b1, 32'hAA}) begin
      bad++; $display("FAIL pre_rst_issue: en=%0b v1=%0h want 1 aa", alu_enable, alu_rs1_value);
    end
    #2 rst = 1'b0;
    #1;
    total++;
    if ({alu_enable, alu_rs1_value, alu_rd_rename, alu_pc} !== '0) begin
      bad++;
      $display("FAIL async_rst: en=%0b v1=%0h rd=%0h pc=%0h want 0",
               alu_enable, alu_rs1_value, alu_rd_rename, alu_pc);
    end
    model_reset();
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_order();
    logic [ROB_W-1:0] first, second;
`ifdef RS_AGE_SELECT_EN
    first = 4'd13; second = 4'd14;
`else
    first = 4'd14; second = 4'd13;
`endif
    drive_disp(OP_BEQ, 4'd10, 0, 32'd0, 4'd4, 1, 32'd1, 4'd0);
    tick();
    drive_disp(OP_BNE, 4'd11, 1, 32'd2, 4'd0, 1, 32'd3, 4'd0);
    tick(); idle();
    alu_cdb_valid = 1'b1; alu_cdb_tag = 4'd4; alu_cdb_value = 32'd4;
    tick(); idle();
    total++;
    if ({alu_enable, alu_rd_rename} !== {1'b1, 4'd11}) begin
      bad++; $display("FAIL order_b: en=%0b rd=%0h want 1 b", alu_enable, alu_rd_rename);
    end
    tick();
    total++;
    if ({alu_enable, alu_rd_rename} !== {1'b1, 4'd10}) begin
      bad++; $display("FAIL order_a: en=%0b rd=%0h want 1 a", alu_enable, alu_rd_rename);
    end
    drive_disp(OP_SLT, 4'd12, 0, 32'd0, 4'd6, 1, 32'd0, 4'd0);
    tick();
    drive_disp(OP_SLT, 4'd13, 0, 32'd0, 4'd8, 1, 32'd0, 4'd0);
    tick(); idle();
    alu_cdb_valid = 1'b1; alu_cdb_tag = 4'd6; alu_cdb_value = 32'd6;
    tick(); idle(); tick();
    total++;
    if ({alu_enable, alu_rd_rename} !== {1'b1, 4'd12}) begin
      bad++; $display("FAIL order_x: en=%0b rd=%0h want 1 c", alu_enable, alu_rd_rename);
    end
    drive_disp(OP_SLT, 4'd14, 0, 32'd0, 4'd8, 1, 32'd0, 4'd0);
    tick(); idle();
    lsb_cdb_valid = 1'b1; lsb_cdb_tag = 4'd8; lsb_cdb_value = 32'd8;
    tick(); idle(); tick();
    total++;
    if ({alu_enable, alu_rd_rename} !== {1'b1, first}) begin
      bad++;
      $display("FAIL order_first: en=%0b rd=%0h want 1 %0h", alu_enable, alu_rd_rename, first);
    end
    tick();
    total++;
    if ({alu_enable, alu_rd_rename} !== {1'b1, second}) begin
      bad++;
      $display("FAIL order_second: en=%0b rd=%0h want 1 %0h", alu_enable, alu_rd_rename, second);
    end
    tick();
  endtask

  task automatic test_random();
    logic [3:0] t;
    for (int c = 0; c < 600; c++) begin
      idle();
      rdy   = ($urandom_range(0, 9) != 0);
      flush = ($urandom_range(0, 39) == 0);
      if (!m_full() && $urandom_range(0, 2) != 0) begin
        drive_disp(6'($urandom_range(0, 19)), 4'($urandom_range(0, 15)),
                   1'($urandom_range(0, 1)), $urandom, 4'($urandom_range(0, 7)),
                   1'($urandom_range(0, 1)), $urandom, 4'($urandom_range(0, 7)));
        disp_pc  = $urandom;
        disp_imm = $urandom;
      end
      t = 4'($urandom_range(0, 7));
      alu_cdb_valid = 1'($urandom_range(0, 1));
      alu_cdb_tag   = t;
      alu_cdb_value = $urandom;
      lsb_cdb_valid = 1'($urandom_range(0, 1));
      lsb_cdb_tag   = 4'((t + 4'd1 + 4'($urandom_range(0, 6))) % 8);
      lsb_cdb_value = $urandom;
      tick();
      total++;
      if ({alu_enable, alu_op, alu_pc, alu_imm, alu_rd_rename,
           alu_rs1_value, alu_rs2_value}
          !== {m_en, m_op, m_pc, m_imm, m_rd, m_v1, m_v2}) begin
        bad++;
        $display("FAIL rand_issue: cyc=%0d en=%0b rd=%0h pc=%0h v1=%0h v2=%0h want %0b %0h %0h %0h %0h",
                 c, alu_enable, alu_rd_rename, alu_pc, alu_rs1_value, alu_rs2_value,
                 m_en, m_rd, m_pc, m_v1, m_v2);
      end
      total++;
      if (rs_full !== m_full()) begin
        bad++; $display("FAIL rand_full: cyc=%0d full=%0b want %0b", c, rs_full, m_full());
      end
    end
    idle();
  endtask

  initial begin
    test_reset();
    test_basic_issue();
    test_cdb_wakeup();
    test_dispatch_snoop();
    test_full();
    test_flush();
    test_order();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/reservation_station.md
Name: reservation_station

Overview:
Integer reservation station sitting directly upstream of the ALU. It buffers decoded ALU/branch/jump instructions whose operands may still be pending, and captures results broadcast by the ALU and the load/store buffer (CDB snoop). Each cycle it selects one entry with both operands ready and issues it to the ALU as a one-cycle enable pulse. It is cleared entirely on a ROB misprediction flush.

Parameters:
RS_SIZE, 16, number of entries (power of two, ≥2)
ROB_W, 4, ROB rename tag width (matches ROBINDEX)
DATA_W, 32, operand/result width
OP_W, 6, opcode width (matches OPLEN)

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, asynchronous, active-low (0 = reset)
rdy  in  1  global ready; 0 freezes all state and outputs
flush  in  1  ROB mispredict rollback; clears all entries
disp_valid  in  1  dispatch request from decoder
disp_op  in  OP_W  opcode
disp_pc  in  32  instruction PC
disp_imm  in  32  sign-extended immediate
disp_rd_rename  in  ROB_W  destination ROB tag
disp_rs1_ready / disp_rs2_ready  in  1 each  operand value already valid
disp_rs1_value / disp_rs2_value  in  DATA_W each  operand value when ready
disp_rs1_tag / disp_rs2_tag  in  ROB_W each  producer tag when not ready
rs_full  out  1  no free entry (combinational from current occupancy)
alu_cdb_valid / alu_cdb_tag / alu_cdb_value  in  1/ROB_W/DATA_W  ALU broadcast
lsb_cdb_valid / lsb_cdb_tag / lsb_cdb_value  in  1/ROB_W/DATA_W  load result broadcast
alu_enable  out  1  issue pulse to ALU
alu_rd_rename  out  ROB_W  issued tag
alu_pc  out  32  issued PC
alu_imm  out  32  issued immediate
alu_rs1_value / alu_rs2_value  out  DATA_W each  issued operands
alu_op  out  OP_W  issued opcode

Behaviour:
- Reset (rst=0, async): all entry busy bits 0; alu_enable=0; all other alu_* outputs 0; rs_full=0.
- rdy=0: no state or output changes; dispatch ignored; broadcasts ignored.
- Entry state: busy, op, pc, imm, rd_rename, per-operand {ready, tag, value}.
- Dispatch (rdy, disp_valid, !rs_full, !flush): written into the lowest-index free entry at the clock edge. disp_valid while rs_full: request dropped, no state change (sim assertion fires).
- Dispatch-cycle snoop: a non-ready operand whose tag matches a valid CDB in the same cycle is stored as ready with the CDB value.
- Wakeup: every busy, non-ready operand compares its tag against both CDBs each cycle; on match ready←1, value←CDB value. If both CDBs match, ALU wins (equal tags are illegal).
- Select/issue: candidates are entries that are busy with both operands ready in *registered* state. A woken entry issues no earlier than the following cycle. Default policy: lowest index wins. Winner fields are registered onto alu_* and alu_enable=1 for exactly one cycle; the entry is freed at the same edge. With no candidate, alu_enable=0 and the other alu_* outputs hold their values.
- Issue latency: dispatch with both operands ready at edge N → alu_enable high after edge N+1.
- Issue and dispatch in the same cycle are allowed. The freed slot is not reusable until the next cycle; rs_full does not count it.
- Flush (rdy=1): all busy←0, alu_enable←0 at the edge. Flush wins over dispatch, wakeup, and issue in the same cycle.
- Branch ops issue like others; the ALU decides broadcast.

Optional Feature:
RS_AGE_SELECT_EN
- Defined: an RS_SIZE×RS_SIZE age matrix records dispatch order. Select picks the oldest ready entry. On dispatch into entry i, row i is set to all busy entries (i is younger than each). Rows and columns are cleared on free and on flush.
- Undefined: lowest-index priority, no age storage.

Decomposition:
- Shared define package: ROB_W/DATA_W/OP_W widths, opcode encodings, TRUE/FALSE, RS_SIZE.
- One sub-module: rs_select. It takes a ready vector (plus the age matrix when RS_AGE_SELECT_EN) and returns a one-hot grant plus a valid flag. The free-slot finder reuses it with policy forced to lowest-index.

Test Plan:
1. Dispatch ADD with rs1=5 and rs2=7 both ready at cycle 0 → alu_enable=1 in cycle 2 for exactly 1 cycle, alu_rs1_value=5, alu_rs2_value=7, alu_rd_rename=disp tag.
2. Dispatch with rs1 tag=3 not ready; alu_cdb tag=3 value=0x1234 two cycles later → issue the cycle after the broadcast with alu_rs1_value=0x1234.
3. Dispatch same cycle as lsb_cdb tag=9 value=42 matching rs2 tag 9 → entry captured ready; issues next cycle with rs2=42.
4. Fill all 16 entries with a pending tag → rs_full=1 and 17th dispatch dropped. Broadcast the tag → 16 issues on consecutive cycles, rs_full=0 after the first free edge.
5. 4 busy entries, flush with a ready entry and a dispatch in the same cycle → alu_enable=0 next cycle, all busy=0. Drive rst low mid-issue → alu_enable=0 immediately.
6. RS_AGE_SELECT_EN: dispatch A→entry0 (pending), B→entry1 (ready), then wake A → B issues before A. Without the macro, the same sequence still issues B first, but entry0 wins once both are ready simultaneously.
